// File: rtl/flit_sender.sv
// flit_sender: output stage of a mesh switch port.
// Pops flits from the port's input FIFO, XY-routes each head flit, locks the
// chosen output for the rest of the wormhole packet and offers every flit to
// the selected neighbour with a valid/ack handshake.

module flit_sender #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int X_COORD   = 0,
    parameter int Y_COORD   = 0
) (
    input  logic                                clk,
    input  logic                                a_rst,
    input  logic                                is_empty,
    input  logic [DATA_SIZE+ADDR_SIZE:0]        data_i,
    output logic                                rd_req,
    input  logic [PORTS_NUM:0]                  out_w,
    output logic [PORTS_NUM:0]                  out_r,
    output logic [DATA_SIZE+ADDR_SIZE:0]        data_o
);

    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int HALF     = ADDR_SIZE / 2;
    localparam int PW       = $clog2(PORTS_NUM + 1);

    localparam logic [HALF-1:0] OWN_X = HALF'(X_COORD);
    localparam logic [HALF-1:0] OWN_Y = HALF'(Y_COORD);

    localparam logic [PW-1:0] PORT_NORTH = PW'(0);
    localparam logic [PW-1:0] PORT_EAST  = PW'(1);
    localparam logic [PW-1:0] PORT_SOUTH = PW'(2);
    localparam logic [PW-1:0] PORT_WEST  = PW'(3);
    localparam logic [PW-1:0] PORT_LOCAL = PW'(PORTS_NUM);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]    state;
    logic          packet_open;
    logic [PW-1:0] port_q;
    logic [PW-1:0] head_port;
    logic          ack;

    // X is resolved first, then Y; equal coordinates deliver locally.
    function automatic logic [PW-1:0] xy_route(input logic [ADDR_SIZE-1:0] addr);
        logic [HALF-1:0] dest_x;
        logic [HALF-1:0] dest_y;
        dest_x = addr[HALF-1:0];
        dest_y = addr[ADDR_SIZE-1:HALF];
        if (dest_x > OWN_X)      return PORT_EAST;
        else if (dest_x < OWN_X) return PORT_WEST;
        else if (dest_y > OWN_Y) return PORT_NORTH;
        else if (dest_y < OWN_Y) return PORT_SOUTH;
        else                     return PORT_LOCAL;
    endfunction

    function automatic logic [PORTS_NUM:0] one_hot(input logic [PW-1:0] p);
        return (PORTS_NUM+1)'(1) << p;
    endfunction

    // Route candidate for the flit arriving from the FIFO, and ack decode on the locked port.
    always_comb begin
        head_port = xy_route(data_i[ADDR_SIZE-1:0]);
        ack       = (out_w[port_q] === 1'b1);
    end

    // Pop / route / offer / wait-for-ack sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= S_IDLE;
            rd_req      <= 1'b0;
            out_r       <= '0;
            data_o      <= '0;
            packet_open <= 1'b0;
            port_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!is_empty) begin
                        rd_req <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    rd_req <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    data_o <= data_i;
                    if (!packet_open) begin
                        port_q      <= head_port;
                        packet_open <= 1'b1;
                        out_r       <= one_hot(head_port);
                    end else begin
                        out_r <= one_hot(port_q);
                    end
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (ack) begin
                        out_r <= '0;
                        if (data_o[ADDR_SIZE]) packet_open <= 1'b0;
                        if (!is_empty) begin
                            rd_req <= 1'b1;
                            state  <= S_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_sender.sv
// tb_flit_sender: directed bench for flit_sender at switch (1,1) in a 4x4 mesh.
// A small FIFO model feeds the DUT; the bench drives acks and checks outputs
// against hand-computed routes and timings.

module tb_flit_sender;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 4;
    localparam int PORTS_NUM = 4;
    localparam int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1;

    logic                clk = 1'b0;
    logic                a_rst = 1'b1;
    logic                is_empty = 1'b1;
    logic [BUS_SIZE-1:0] data_i = '0;
    logic                rd_req;
    logic [PORTS_NUM:0]  out_w = '0;
    logic [PORTS_NUM:0]  out_r;
    logic [BUS_SIZE-1:0] data_o;

    logic                push_en = 1'b0;
    logic [BUS_SIZE-1:0] push_flit = '0;
    logic [BUS_SIZE-1:0] fifo_q[$];
    int                  rd_count = 0;
    int                  rd_while_empty = 0;

    int checkCount = 0;
    int passCount  = 0;

    flit_sender #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE),
        .PORTS_NUM(PORTS_NUM),
        .X_COORD(1),
        .Y_COORD(1)
    ) dut (
        .clk(clk),
        .a_rst(a_rst),
        .is_empty(is_empty),
        .data_i(data_i),
        .rd_req(rd_req),
        .out_w(out_w),
        .out_r(out_r),
        .data_o(data_o)
    );

    always #5 clk = ~clk;

    // FIFO model: push from the bench, pop on rd_req with data valid the next cycle.
    always @(posedge clk) begin
        if (push_en) fifo_q.push_back(push_flit);
        if (rd_req) begin
            rd_count <= rd_count + 1;
            if (is_empty) rd_while_empty <= rd_while_empty + 1;
            if (fifo_q.size() != 0) data_i <= fifo_q.pop_front();
        end
        is_empty <= (fifo_q.size() == 0);
    end

    // Hard stop in case some handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [BUS_SIZE-1:0] mk(input logic [31:0] payload, input logic tail,
                                               input logic [3:0] addr);
        return {payload, tail, addr};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        else
            passCount++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one flit into the FIFO model; returns just after the edge that stored it.
    task automatic applyStimulus(input logic [BUS_SIZE-1:0] f);
        push_flit = f;
        push_en   = 1'b1;
        @(posedge clk);
        #1;
        push_en = 1'b0;
    endtask

    task automatic waitValid(output int cyc);
        cyc = 0;
        while (out_r == '0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic sendAck(input int port);
        out_w = (PORTS_NUM+1)'(1) << port;
        @(posedge clk);
        #1;
        out_w = '0;
    endtask

    logic [BUS_SIZE-1:0] f;
    int cyc;
    int rd0;

    initial begin
        tick(3);
        a_rst = 1'b0;
        tick(1);
        checkOutput("reset_rd_req", 64'(rd_req), 64'd0);
        checkOutput("reset_out_r", 64'(out_r), 64'd0);
        checkOutput("reset_data_o", 64'(data_o), 64'd0);

        // 1: async reset mid-cycle while holding a flit, FIFO still non-empty
        applyStimulus(mk(32'h0000_0001, 1'b1, 4'b0110));
        waitValid(cyc);
        checkOutput("t1_pre_out_r", 64'(out_r), 64'b00010);
        rd0 = rd_count;
        f = mk(32'h0000_0002, 1'b1, 4'b0110);
        applyStimulus(f);
        tick(2);
        checkOutput("t1_no_rd_while_held", 64'(rd_count - rd0), 64'd0);
        #3 a_rst = 1'b1;
        #1;
        checkOutput("t1_async_rd_req", 64'(rd_req), 64'd0);
        checkOutput("t1_async_out_r", 64'(out_r), 64'd0);
        checkOutput("t1_async_data_o", 64'(data_o), 64'd0);
        tick(4);
        checkOutput("t1_no_rd_in_reset", 64'(rd_count - rd0), 64'd0);
        a_rst = 1'b0;
        waitValid(cyc);
        checkOutput("t1_after_out_r", 64'(out_r), 64'b00010);
        checkOutput("t1_after_data_o", 64'(data_o), 64'(f));
        sendAck(1);

        // 2: single-flit packet East, 3-edge latency, single pop
        tick(2);
        rd0 = rd_count;
        f = mk(32'hDEAD_BEEF, 1'b1, 4'b0110);
        applyStimulus(f);
        waitValid(cyc);
        checkOutput("t2_latency", 64'(cyc), 64'd3);
        checkOutput("t2_out_r", 64'(out_r), 64'b00010);
        checkOutput("t2_data_o", 64'(data_o), 64'(f));
        sendAck(1);
        checkOutput("t2_out_r_clear", 64'(out_r), 64'd0);
        tick(3);
        checkOutput("t2_one_pop", 64'(rd_count - rd0), 64'd1);
        checkOutput("t2_idle_rd_req", 64'(rd_req), 64'd0);

        // 3: three-flit local packet, then West head after the tail released the lock
        applyStimulus(mk(32'h0000_0011, 1'b0, 4'b0101));
        applyStimulus(mk(32'h0000_0022, 1'b0, 4'b0000));
        applyStimulus(mk(32'h0000_0033, 1'b1, 4'b0000));
        for (int i = 0; i < 3; i++) begin
            waitValid(cyc);
            checkOutput($sformatf("t3_flit%0d_out_r", i), 64'(out_r), 64'b10000);
            checkOutput($sformatf("t3_flit%0d_data", i), 64'(data_o[DATA_SIZE+ADDR_SIZE:ADDR_SIZE+1]),
                        64'(32'h11 * (i + 1)));
            sendAck(4);
        end
        f = mk(32'h0000_0044, 1'b1, 4'b0100);
        applyStimulus(f);
        waitValid(cyc);
        checkOutput("t3_west_out_r", 64'(out_r), 64'b01000);
        checkOutput("t3_west_data_o", 64'(data_o), 64'(f));
        sendAck(3);

        // 4: North with ack withheld; a wrong-port ack and an X ack are ignored
        f = mk(32'h55AA_55AA, 1'b1, 4'b1101);
        applyStimulus(f);
        waitValid(cyc);
        checkOutput("t4_out_r", 64'(out_r), 64'b00001);
        for (int i = 0; i < 5; i++) begin
            out_w = (i == 2) ? 5'b00100 : ((i == 3) ? 5'bxxxxx : 5'b00000);
            @(posedge clk);
            #1;
            out_w = '0;
            checkOutput($sformatf("t4_hold%0d_out_r", i), 64'(out_r), 64'b00001);
            checkOutput($sformatf("t4_hold%0d_data", i), 64'(data_o), 64'(f));
        end
        sendAck(0);
        checkOutput("t4_done_out_r", 64'(out_r), 64'd0);

        // 5: back-to-back single-flit packets, next pop right after the ack
        tick(2);
        applyStimulus(mk(32'h0000_0066, 1'b1, 4'b0110));
        f = mk(32'h0000_0077, 1'b1, 4'b1101);
        applyStimulus(f);
        waitValid(cyc);
        checkOutput("t5_first_out_r", 64'(out_r), 64'b00010);
        sendAck(1);
        checkOutput("t5_rd_req_after_ack", 64'(rd_req), 64'd1);
        waitValid(cyc);
        checkOutput("t5_second_latency", 64'(cyc), 64'd2);
        checkOutput("t5_second_out_r", 64'(out_r), 64'b00001);
        checkOutput("t5_second_data", 64'(data_o), 64'(f));
        sendAck(0);

        // 6: reset during flit 2 of an East packet; next flit must be routed as a head
        tick(2);
        applyStimulus(mk(32'h0000_00A1, 1'b0, 4'b0110));
        applyStimulus(mk(32'h0000_00A2, 1'b0, 4'b0000));
        waitValid(cyc);
        checkOutput("t6_head_out_r", 64'(out_r), 64'b00010);
        sendAck(1);
        waitValid(cyc);
        checkOutput("t6_body_out_r", 64'(out_r), 64'b00010);
        #3 a_rst = 1'b1;
        tick(2);
        a_rst = 1'b0;
        // addr 0001: x=1 equals own x, y=0 below own y -> South (port 2)
        f = mk(32'h0000_00B1, 1'b1, 4'b0001);
        applyStimulus(f);
        waitValid(cyc);
        checkOutput("t6_new_head_out_r", 64'(out_r), 64'b00100);
        checkOutput("t6_new_head_data", 64'(data_o), 64'(f));
        sendAck(2);
        checkOutput("t6_done_out_r", 64'(out_r), 64'd0);

        tick(2);
        checkOutput("rd_req_while_empty", 64'(rd_while_empty), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
